// File: rtl/dual_fetch_unit.sv
// ---------------------------------------------------------------------------
// dual_fetch_unit
//
// Front end of the 2-wide in-order core. Every cycle it fetches an aligned
// instruction pair (slot A at the fetch PC, slot B at fetch PC + 4) from a
// synchronous-read instruction memory with one cycle of read latency, and
// presents the returned pair together with its decode PC to the issue logic.
// Supports stall (hold the presented pair), flush (squash the presented and
// in-flight pair) and taken-branch redirect (one NOP bubble per redirect).
//
// Ports:
//   clk            core clock, all state changes on the rising edge
//   reset          asynchronous active-low reset
//   stall          issue logic cannot accept the current pair
//   flush          squash the presented pair and the pair in flight
//   branch_target  redirect address, bits [1:0] treated as zero
//   branch_taken   redirect fetch to branch_target
//   pc             decode PC (address of inst_a)
//   next_pc        value the fetch PC takes at the next rising edge
//   imem_addr_a    fetch address, slot A
//   imem_addr_b    fetch address, slot B
//   inst_a/inst_b  presented instruction pair
//   imem_data_a/b  memory read data for the previous cycle's addresses
// ---------------------------------------------------------------------------
module dual_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] branch_target,
  input  logic        branch_taken,
  output logic [31:0] pc,
  output logic [31:0] next_pc,
  output logic [31:0] imem_addr_a,
  output logic [31:0] imem_addr_b,
  output logic [31:0] inst_a,
  output logic [31:0] inst_b,
  input  logic [31:0] imem_data_a,
  input  logic [31:0] imem_data_b
);

  logic [31:0] fpc_r;
  logic [31:0] dpc_r;
  logic        dvalid_r;
  logic        held_r;
  logic [31:0] hold_a_r;
  logic [31:0] hold_b_r;

  logic [31:0] next_pc_s;
  logic [31:0] inst_a_s;
  logic [31:0] inst_b_s;

  // Next fetch PC: redirect beats stall; flush alone continues sequentially.
  // While reset is asserted the reset PC is reported directly.
  always_comb begin
    next_pc_s = fpc_r + 32'd8;
    if (!reset) begin
      next_pc_s = RESET_PC;
    end else if (branch_taken) begin
      next_pc_s = branch_target & 32'hFFFF_FFFC;
    end else if (stall) begin
      next_pc_s = fpc_r;
    end else begin
      next_pc_s = fpc_r + 32'd8;
    end
  end

  // Presented pair: NOP for an empty slot, captured copy while stalled,
  // otherwise the memory read data (which lags the address by one cycle).
  always_comb begin
    inst_a_s = NOP_INST;
    inst_b_s = NOP_INST;
    if (!dvalid_r) begin
      inst_a_s = NOP_INST;
      inst_b_s = NOP_INST;
    end else if (held_r) begin
      inst_a_s = hold_a_r;
      inst_b_s = hold_b_r;
    end else begin
      inst_a_s = imem_data_a;
      inst_b_s = imem_data_b;
    end
  end

  // Fetch/decode state update. The memory keeps reading the stalled fetch
  // address and its data moves on to the next pair, so the presented pair is
  // captured on the first stalled edge and replayed until the stall ends.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fpc_r    <= RESET_PC;
      dpc_r    <= RESET_PC;
      dvalid_r <= 1'b0;
      held_r   <= 1'b0;
      hold_a_r <= NOP_INST;
      hold_b_r <= NOP_INST;
    end else if (branch_taken || flush) begin
      fpc_r    <= next_pc_s;
      dpc_r    <= fpc_r;
      dvalid_r <= 1'b0;
      held_r   <= 1'b0;
    end else if (stall) begin
      if (!held_r) begin
        hold_a_r <= inst_a_s;
        hold_b_r <= inst_b_s;
        held_r   <= 1'b1;
      end
    end else begin
      fpc_r    <= fpc_r + 32'd8;
      dpc_r    <= fpc_r;
      dvalid_r <= 1'b1;
      held_r   <= 1'b0;
    end
  end

  assign pc          = dpc_r;
  assign next_pc     = next_pc_s;
  assign imem_addr_a = fpc_r;
  assign imem_addr_b = fpc_r + 32'd4;
  assign inst_a      = inst_a_s;
  assign inst_b      = inst_b_s;

endmodule

// File: tb/tb_dual_fetch_unit.sv
// Directed bench for dual_fetch_unit. Memory word at address A holds
// 32'h1000_0000 + A/4, returned one clock after the address is presented.
module tb_dual_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [31:0] branch_target;
  logic        branch_taken;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic [31:0] imem_addr_a;
  logic [31:0] imem_addr_b;
  logic [31:0] inst_a;
  logic [31:0] inst_b;
  logic [31:0] imem_data_a;
  logic [31:0] imem_data_b;

  int vectors;
  int miscompares;

  dual_fetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .branch_target (branch_target),
    .branch_taken  (branch_taken),
    .pc            (pc),
    .next_pc       (next_pc),
    .imem_addr_a   (imem_addr_a),
    .imem_addr_b   (imem_addr_b),
    .inst_a        (inst_a),
    .inst_b        (inst_b),
    .imem_data_a   (imem_data_a),
    .imem_data_b   (imem_data_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] word_at(input logic [31:0] addr);
    return 32'h1000_0000 + {2'b00, addr[31:2]};
  endfunction

  // Synchronous-read instruction memory, one cycle of latency.
  always @(posedge clk) begin
    imem_data_a <= word_at(imem_addr_a);
    imem_data_b <= word_at(imem_addr_b);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp_v);
    // intentionally unused: comparisons are inline per test
  endtask

  task automatic test_reset;
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    branch_taken = 1'b0; branch_target = 32'h0;
    repeat (2) @(negedge clk);
    vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL rst_pc got %h exp %h", pc, 32'h0); end
    vectors++; if (inst_a !== NOP) begin miscompares++; $display("FAIL rst_inst_a got %h exp %h", inst_a, NOP); end
    vectors++; if (inst_b !== NOP) begin miscompares++; $display("FAIL rst_inst_b got %h exp %h", inst_b, NOP); end
    vectors++; if (imem_addr_a !== 32'h0) begin miscompares++; $display("FAIL rst_addr_a got %h exp %h", imem_addr_a, 32'h0); end
    vectors++; if (imem_addr_b !== 32'h4) begin miscompares++; $display("FAIL rst_addr_b got %h exp %h", imem_addr_b, 32'h4); end
    vectors++; if (next_pc !== 32'h0) begin miscompares++; $display("FAIL rst_next_pc got %h exp %h", next_pc, 32'h0); end
    reset = 1'b1;
    #1;
    vectors++; if (inst_a !== NOP) begin miscompares++; $display("FAIL rel_c1_inst_a got %h exp %h", inst_a, NOP); end
    vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL rel_c1_pc got %h exp %h", pc, 32'h0); end
    vectors++; if (next_pc !== 32'h8) begin miscompares++; $display("FAIL rel_c1_next_pc got %h exp %h", next_pc, 32'h8); end
  endtask

  task automatic test_sequential;
    @(negedge clk);
    vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL seq0_pc got %h exp %h", pc, 32'h0); end
    vectors++; if (inst_a !== 32'h1000_0000) begin miscompares++; $display("FAIL seq0_inst_a got %h exp %h", inst_a, 32'h1000_0000); end
    vectors++; if (inst_b !== 32'h1000_0001) begin miscompares++; $display("FAIL seq0_inst_b got %h exp %h", inst_b, 32'h1000_0001); end
    vectors++; if (imem_addr_a !== 32'h8) begin miscompares++; $display("FAIL seq0_addr_a got %h exp %h", imem_addr_a, 32'h8); end
    @(negedge clk);
    vectors++; if (pc !== 32'h8) begin miscompares++; $display("FAIL seq1_pc got %h exp %h", pc, 32'h8); end
    vectors++; if (inst_a !== 32'h1000_0002) begin miscompares++; $display("FAIL seq1_inst_a got %h exp %h", inst_a, 32'h1000_0002); end
    vectors++; if (inst_b !== 32'h1000_0003) begin miscompares++; $display("FAIL seq1_inst_b got %h exp %h", inst_b, 32'h1000_0003); end
    vectors++; if (imem_addr_a !== 32'h10) begin miscompares++; $display("FAIL seq1_addr_a got %h exp %h", imem_addr_a, 32'h10); end
  endtask

  task automatic test_stall;
    stall = 1'b1;
    #1;
    vectors++; if (next_pc !== 32'h10) begin miscompares++; $display("FAIL stall_next_pc got %h exp %h", next_pc, 32'h10); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++; if (pc !== 32'h8) begin miscompares++; $display("FAIL stall%0d_pc got %h exp %h", i, pc, 32'h8); end
      vectors++; if (inst_a !== 32'h1000_0002) begin miscompares++; $display("FAIL stall%0d_inst_a got %h exp %h", i, inst_a, 32'h1000_0002); end
      vectors++; if (inst_b !== 32'h1000_0003) begin miscompares++; $display("FAIL stall%0d_inst_b got %h exp %h", i, inst_b, 32'h1000_0003); end
    end
    stall = 1'b0;
    @(negedge clk);
    vectors++; if (pc !== 32'h10) begin miscompares++; $display("FAIL unstall_pc got %h exp %h", pc, 32'h10); end
    vectors++; if (inst_a !== 32'h1000_0004) begin miscompares++; $display("FAIL unstall_inst_a got %h exp %h", inst_a, 32'h1000_0004); end
    vectors++; if (inst_b !== 32'h1000_0005) begin miscompares++; $display("FAIL unstall_inst_b got %h exp %h", inst_b, 32'h1000_0005); end
  endtask

  task automatic test_branch;
    branch_taken = 1'b1; branch_target = 32'h40;
    #1;
    vectors++; if (next_pc !== 32'h40) begin miscompares++; $display("FAIL br_next_pc got %h exp %h", next_pc, 32'h40); end
    @(negedge clk);
    branch_taken = 1'b0;
    vectors++; if (inst_a !== NOP) begin miscompares++; $display("FAIL br_bub_inst_a got %h exp %h", inst_a, NOP); end
    vectors++; if (inst_b !== NOP) begin miscompares++; $display("FAIL br_bub_inst_b got %h exp %h", inst_b, NOP); end
    vectors++; if (imem_addr_a !== 32'h40) begin miscompares++; $display("FAIL br_bub_addr_a got %h exp %h", imem_addr_a, 32'h40); end
    @(negedge clk);
    vectors++; if (pc !== 32'h40) begin miscompares++; $display("FAIL br_tgt_pc got %h exp %h", pc, 32'h40); end
    vectors++; if (inst_a !== 32'h1000_0010) begin miscompares++; $display("FAIL br_tgt_inst_a got %h exp %h", inst_a, 32'h1000_0010); end
    vectors++; if (inst_b !== 32'h1000_0011) begin miscompares++; $display("FAIL br_tgt_inst_b got %h exp %h", inst_b, 32'h1000_0011); end
  endtask

  task automatic test_branch_over_stall;
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h46;
    #1;
    vectors++; if (next_pc !== 32'h44) begin miscompares++; $display("FAIL brst_next_pc got %h exp %h", next_pc, 32'h44); end
    @(negedge clk);
    stall = 1'b0; branch_taken = 1'b0;
    vectors++; if (imem_addr_a !== 32'h44) begin miscompares++; $display("FAIL brst_fpc got %h exp %h", imem_addr_a, 32'h44); end
    vectors++; if (inst_a !== NOP) begin miscompares++; $display("FAIL brst_bub_inst_a got %h exp %h", inst_a, NOP); end
    @(negedge clk);
    vectors++; if (pc !== 32'h44) begin miscompares++; $display("FAIL brst_pc got %h exp %h", pc, 32'h44); end
    vectors++; if (inst_a !== 32'h1000_0011) begin miscompares++; $display("FAIL brst_inst_a got %h exp %h", inst_a, 32'h1000_0011); end
    vectors++; if (inst_b !== 32'h1000_0012) begin miscompares++; $display("FAIL brst_inst_b got %h exp %h", inst_b, 32'h1000_0012); end
  endtask

  task automatic test_flush;
    flush = 1'b1;
    #1;
    vectors++; if (next_pc !== 32'h54) begin miscompares++; $display("FAIL fl_next_pc got %h exp %h", next_pc, 32'h54); end
    @(negedge clk);
    flush = 1'b0;
    vectors++; if (inst_a !== NOP) begin miscompares++; $display("FAIL fl_bub_inst_a got %h exp %h", inst_a, NOP); end
    vectors++; if (inst_b !== NOP) begin miscompares++; $display("FAIL fl_bub_inst_b got %h exp %h", inst_b, NOP); end
    @(negedge clk);
    vectors++; if (pc !== 32'h54) begin miscompares++; $display("FAIL fl_pc got %h exp %h", pc, 32'h54); end
    vectors++; if (inst_a !== 32'h1000_0015) begin miscompares++; $display("FAIL fl_inst_a got %h exp %h", inst_a, 32'h1000_0015); end
    vectors++; if (inst_b !== 32'h1000_0016) begin miscompares++; $display("FAIL fl_inst_b got %h exp %h", inst_b, 32'h1000_0016); end
  endtask

  task automatic test_wrap_and_async_reset;
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFF8;
    @(negedge clk);
    branch_taken = 1'b0;
    #1;
    vectors++; if (imem_addr_a !== 32'hFFFF_FFF8) begin miscompares++; $display("FAIL wr_addr_a got %h exp %h", imem_addr_a, 32'hFFFF_FFF8); end
    vectors++; if (imem_addr_b !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wr_addr_b got %h exp %h", imem_addr_b, 32'hFFFF_FFFC); end
    vectors++; if (next_pc !== 32'h0) begin miscompares++; $display("FAIL wr_next_pc got %h exp %h", next_pc, 32'h0); end
    @(negedge clk);
    vectors++; if (pc !== 32'hFFFF_FFF8) begin miscompares++; $display("FAIL wr_pc got %h exp %h", pc, 32'hFFFF_FFF8); end
    vectors++; if (inst_a !== 32'h4FFF_FFFE) begin miscompares++; $display("FAIL wr_inst_a got %h exp %h", inst_a, 32'h4FFF_FFFE); end
    vectors++; if (inst_b !== 32'h4FFF_FFFF) begin miscompares++; $display("FAIL wr_inst_b got %h exp %h", inst_b, 32'h4FFF_FFFF); end
    vectors++; if (imem_addr_a !== 32'h0) begin miscompares++; $display("FAIL wr_fpc got %h exp %h", imem_addr_a, 32'h0); end
    stall = 1'b1;
    @(negedge clk);
    vectors++; if (pc !== 32'hFFFF_FFF8) begin miscompares++; $display("FAIL wr_stall_pc got %h exp %h", pc, 32'hFFFF_FFF8); end
    // Assert reset away from any clock edge; outputs must follow at once.
    #2 reset = 1'b0;
    #1;
    vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL ar_pc got %h exp %h", pc, 32'h0); end
    vectors++; if (inst_a !== NOP) begin miscompares++; $display("FAIL ar_inst_a got %h exp %h", inst_a, NOP); end
    vectors++; if (inst_b !== NOP) begin miscompares++; $display("FAIL ar_inst_b got %h exp %h", inst_b, NOP); end
    vectors++; if (imem_addr_a !== 32'h0) begin miscompares++; $display("FAIL ar_addr_a got %h exp %h", imem_addr_a, 32'h0); end
    vectors++; if (imem_addr_b !== 32'h4) begin miscompares++; $display("FAIL ar_addr_b got %h exp %h", imem_addr_b, 32'h4); end
    vectors++; if (next_pc !== 32'h0) begin miscompares++; $display("FAIL ar_next_pc got %h exp %h", next_pc, 32'h0); end
    @(negedge clk);
    stall = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    vectors++; if (inst_a !== 32'h1000_0000) begin miscompares++; $display("FAIL ar_rel_inst_a got %h exp %h", inst_a, 32'h1000_0000); end
    vectors++; if (pc !== 32'h0) begin miscompares++; $display("FAIL ar_rel_pc got %h exp %h", pc, 32'h0); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_branch_over_stall();
    test_flush();
    test_wrap_and_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dual_fetch_unit.md
Name: dual_fetch_unit

Overview:
- Front end of the 2-wide in-order RISC-V superscalar core. Fetches an aligned instruction pair every cycle from a synchronous-read instruction memory (1-cycle latency).
- Presents the pair plus its PC to the downstream issue logic. Slot A is at pc; slot B is implicitly at pc+4.
- Handles stall (hold), flush (squash) and taken-branch redirect.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INST, 32'h0000_0013, instruction presented in a squashed or empty slot (addi x0,x0,0).

Ports:
- clk  in  1  core clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- stall  in  1  issue logic cannot accept the current pair; hold everything.
- flush  in  1  squash the pair currently presented and the pair in flight.
- branch_target  in  32  redirect address; bits [1:0] are ignored and treated as 0.
- branch_taken  in  1  redirect fetch to branch_target.
- pc  out  32  address of the instruction on inst_a (decode PC).
- next_pc  out  32  value the fetch PC takes at the next rising edge.
- imem_addr_a  out  32  fetch address, slot A (= fetch PC).
- imem_addr_b  out  32  fetch address, slot B (= fetch PC + 4, modulo 2^32).
- inst_a  out  32  instruction at pc.
- inst_b  out  32  instruction at pc+4.
- imem_data_a  in  32  memory read data for the previous cycle's imem_addr_a.
- imem_data_b  in  32  memory read data for the previous cycle's imem_addr_b.

Behaviour:
- State:
  - fpc: fetch PC, 32 bits.
  - dpc: decode PC, 32 bits.
  - dvalid: decode slot valid, 1 bit.
  - held: capture flag, 1 bit.
  - hold_a / hold_b: capture registers, 32 bits each.
- Reset (reset=0, asynchronous):
  - fpc = dpc = RESET_PC; dvalid = 0; held = 0; hold_a = hold_b = NOP_INST.
  - Outputs: pc = RESET_PC, inst_a = inst_b = NOP_INST, imem_addr_a = RESET_PC, imem_addr_b = RESET_PC+4, next_pc = RESET_PC.
- Addresses are combinational: imem_addr_a = fpc; imem_addr_b = fpc+4.
- next_pc, in priority order:
  - branch_taken → {branch_target[31:2], 2'b00}
  - else stall → fpc (flush alone does not redirect)
  - else fpc+8
  - All arithmetic is modulo 2^32; wrap-around is silent.
- Rising edge, not in reset, first matching case applies:
  1. branch_taken or flush: fpc <= next_pc; dpc <= fpc; dvalid <= 0; held <= 0. This case overrides stall.
  2. stall: fpc and dpc unchanged. If held=0: hold_a/hold_b <= current inst_a/inst_b, held <= 1. dvalid unchanged.
  3. otherwise: fpc <= fpc+8; dpc <= fpc; dvalid <= 1; held <= 0.
- Output selection (combinational):
  - pc = dpc.
  - inst_x = NOP_INST if dvalid=0; else hold_x if held=1; else imem_data_x.
- Latency: an address issued in cycle N appears on inst_a/inst_b with pc = that address in cycle N+1.
- Stall semantics:
  - The presented pair and pc stay stable for the full duration of the stall, however long.
  - After stall deasserts, the next pair is at dpc+8 with no duplication or loss.
- Redirect:
  - The cycle after branch_taken presents a NOP bubble pair.
  - The following cycle presents the pair at the target.
  - Exactly one bubble cycle per redirect.
- flush without branch_taken: one NOP bubble; fetch continues sequentially from fpc+8.
- Reset deasserting: the first cycle after reset shows NOPs at pc=RESET_PC (dvalid=0); the pair at RESET_PC appears one cycle later.
- Reset asserted mid-stall or mid-redirect: all state returns immediately to reset values.
- No combinational path from imem_data_x to next_pc or the imem addresses.

Test Plan:
- Reset release, memory word i = 32'h1000_0000+i, no stall: cycle 1 NOP/NOP at pc=0; then pairs (0x10000000, 0x10000001) at pc=0, (0x10000002, 0x10000003) at pc=8; imem_addr_a steps 0, 8, 16.
- Stall held 3 cycles while pc=8: pc stays 8 and insts stay 0x10000002/0x10000003 each cycle; after release the next pair is pc=0x10 with 0x10000004/0x10000005.
- branch_taken with target 0x40 while pc=8: next_pc=0x40 that cycle; next cycle NOP/NOP; following cycle pc=0x40 with words 16/17.
- branch_target 0x46 with stall=1 and branch_taken=1 together: redirect wins; fpc=0x44; one bubble, then pc=0x44.
- flush alone at pc=0x10: next cycle NOP/NOP, then pc=0x20 (sequential continuation).
- fpc=0xFFFF_FFF8: imem_addr_b=0xFFFF_FFFC; next_pc wraps to 0x0000_0000; async reset asserted mid-stall returns all outputs to their reset values without waiting for a clock.
